// File: rtl/adder_chk_pkg.sv
// Shared FSM encoding and sweep-size helper for the adder response checker.
// Imported by the compare stage and the checker top.
package adder_chk_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_RUN   = 2'd1;
    localparam state_t ST_DRAIN = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

    // Exhaustive sweep size: every (A, B, cin) combination.
    function automatic longint unsigned total_vecs(input int unsigned width);
        return longint'(1) << (2 * width + 1);
    endfunction

endpackage

// File: rtl/adder_chk_cmp.sv
// Sample register plus golden-sum compare for the adder response checker.
// out_vld is registered; out_mis is derived from the registered sample.
module adder_chk_cmp
    import adder_chk_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_vld,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [WIDTH-1:0] sum,
    input  logic             cout,
    output logic             out_vld,
    output logic             out_mis,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic             out_cin
);

    logic             vld_q, vld_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             cin_q, cin_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic [WIDTH:0]   exp_w;

    always_comb begin
        vld_d  = in_vld;
        a_d    = a_q;
        b_d    = b_q;
        cin_d  = cin_q;
        sum_d  = sum_q;
        cout_d = cout_q;
        if (in_vld) begin
            a_d    = a;
            b_d    = b;
            cin_d  = cin;
            sum_d  = sum;
            cout_d = cout;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q  <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            cin_q  <= 1'b0;
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            vld_q  <= vld_d;
            a_q    <= a_d;
            b_q    <= b_d;
            cin_q  <= cin_d;
            sum_q  <= sum_d;
            cout_q <= cout_d;
        end
    end

    // Full-width golden sum so the carry-out is checked too.
    always_comb begin
        exp_w = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, cin_q};
    end

    assign out_vld = vld_q;
    assign out_mis = ({cout_q, sum_q} != exp_w);
    assign out_a   = a_q;
    assign out_b   = b_q;
    assign out_cin = cin_q;

endmodule

// File: rtl/adder_resp_checker.sv
// Exhaustive-sweep response checker: FSM, vector/error counters, first-fail capture.
// First-fail capture is built only when ADDER_CHK_FIRST_FAIL_EN is defined.
module adder_resp_checker
    import adder_chk_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 vld,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 cin,
    input  logic [WIDTH-1:0]     sum,
    input  logic                 cout,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [2*WIDTH+1:0]   vec_cnt,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic [WIDTH-1:0]     fail_a,
    output logic [WIDTH-1:0]     fail_b,
    output logic                 fail_cin,
    output logic                 fail_vld
);

    localparam int           VW    = 2 * WIDTH + 2;
    localparam logic [VW-1:0] TOTAL = VW'(total_vecs(WIDTH));
    localparam logic [VW-1:0] LAST  = TOTAL - 1'b1;

    state_t               state_q, state_d;
    logic [VW-1:0]        acc_q, acc_d;
    logic [VW-1:0]        vec_q, vec_d;
    logic [ERR_CNT_W-1:0] err_q, err_d;
    logic                 accept;
    logic                 s2_vld;
    logic                 s2_mis;
    logic [WIDTH-1:0]     s2_a;
    logic [WIDTH-1:0]     s2_b;
    logic                 s2_cin;

    // start has priority, so a sample presented alongside it is dropped.
    assign accept = (state_q == ST_RUN) && vld && !start && (acc_q < TOTAL);

    adder_chk_cmp #(.WIDTH(WIDTH)) u_cmp (
        .clk     (clk),
        .rst     (rst),
        .in_vld  (accept),
        .a       (a),
        .b       (b),
        .cin     (cin),
        .sum     (sum),
        .cout    (cout),
        .out_vld (s2_vld),
        .out_mis (s2_mis),
        .out_a   (s2_a),
        .out_b   (s2_b),
        .out_cin (s2_cin)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        vec_d   = vec_q;
        err_d   = err_q;
        if (start) begin
            state_d = ST_RUN;
            acc_d   = '0;
            vec_d   = '0;
            err_d   = '0;
        end else begin
            case (state_q)
                ST_RUN:   if (accept && acc_q == LAST) state_d = ST_DRAIN;
                ST_DRAIN: state_d = ST_DONE;
                default:  state_d = state_q;
            endcase
            if (accept) acc_d = acc_q + 1'b1;
            if (s2_vld) vec_d = vec_q + 1'b1;
            if (s2_vld && s2_mis && err_q != {ERR_CNT_W{1'b1}})
                err_d = err_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            vec_q   <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            vec_q   <= vec_d;
            err_q   <= err_d;
        end
    end

`ifdef ADDER_CHK_FIRST_FAIL_EN
    logic [WIDTH-1:0] fa_q, fa_d;
    logic [WIDTH-1:0] fb_q, fb_d;
    logic             fc_q, fc_d;
    logic             fv_q, fv_d;

    always_comb begin
        fa_d = fa_q;
        fb_d = fb_q;
        fc_d = fc_q;
        fv_d = fv_q;
        if (start) begin
            fa_d = '0;
            fb_d = '0;
            fc_d = 1'b0;
            fv_d = 1'b0;
        end else if (s2_vld && s2_mis && !fv_q) begin
            fa_d = s2_a;
            fb_d = s2_b;
            fc_d = s2_cin;
            fv_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fa_q <= '0;
            fb_q <= '0;
            fc_q <= 1'b0;
            fv_q <= 1'b0;
        end else begin
            fa_q <= fa_d;
            fb_q <= fb_d;
            fc_q <= fc_d;
            fv_q <= fv_d;
        end
    end

    assign fail_a   = fa_q;
    assign fail_b   = fb_q;
    assign fail_cin = fc_q;
    assign fail_vld = fv_q;
`else
    logic unused_fail;
    assign unused_fail = ^{s2_a, s2_b, s2_cin};
    assign fail_a      = '0;
    assign fail_b      = '0;
    assign fail_cin    = 1'b0;
    assign fail_vld    = 1'b0;
`endif

    assign busy    = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done    = (state_q == ST_DONE);
    assign pass    = done && (err_q == '0);
    assign vec_cnt = vec_q;
    assign err_cnt = err_q;

endmodule

// File: doc/adder_resp_checker.md
# adder_resp_checker

Synthesizable response checker for the parameterized gate-level adder. It samples each stimulus vector (A, B, cin) together with the adder's response (Sum, cout) and compares the pair against a behavioural golden sum. It counts vectors and mismatches, captures the first failing vector, and raises done/pass once the full 2^(2·WIDTH+1) space has been checked. It sits beside the adder on the FPGA as the receiving end of the exhaustive sweep stimulus.

## Interface
- WIDTH, 4: adder operand width; must match the adder's SIZE.
- ERR_CNT_W, 8: mismatch counter width; the counter saturates.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; clears all results and enters RUN
- vld  in  1  current a/b/cin/sum/cout form a valid sample
- a  in  WIDTH  stimulus operand A
- b  in  WIDTH  stimulus operand B
- cin  in  1  stimulus carry-in
- sum  in  WIDTH  adder Sum
- cout  in  1  adder carry-out
- busy  out  1  high in RUN and DRAIN
- done  out  1  high in DONE
- pass  out  1  done && err_cnt==0
- vec_cnt  out  2·WIDTH+2  number of vectors checked
- err_cnt  out  ERR_CNT_W  mismatches, saturating at all-ones
- fail_a  out  WIDTH  A of the first failing vector
- fail_b  out  WIDTH  B of the first failing vector
- fail_cin  out  1  cin of the first failing vector
- fail_vld  out  1  first-fail capture holds data

## Operation
- FSM states and transitions:
  - IDLE → RUN on start.
  - RUN → DRAIN on the edge that accepts sample number TOTAL = 2^(2·WIDTH+1).
  - DRAIN → DONE after one cycle.
  - DONE → RUN on start.
- Accepted sample: vld=1 in RUN while the accepted count is below TOTAL. vld in IDLE, DRAIN or DONE is ignored.
- Stage 1 registers a, b, cin, sum and cout.
- Stage 2 computes exp = a + b + cin, zero-extended to WIDTH+1 bits, with no truncation. mismatch = {cout,sum} != exp.
- On a stage-2 valid:
  - vec_cnt increments by 1.
  - On mismatch, err_cnt increments and holds at all-ones once saturated.
  - On the first mismatch since start, fail_* and fail_vld are captured. Later mismatches do not overwrite them.
- start in any state:
  - Clears vec_cnt, err_cnt, fail_* and the pipeline valid on the next edge, and the state becomes RUN.
  - start and vld in the same cycle: start wins and that sample is discarded.
- The input vector order does not matter. Duplicate vectors are counted again; there is no coverage tracking.

## Timing
- Reset values (asynchronous, immediate on rst): state IDLE, all outputs 0.
- Latency: a sample accepted at edge k updates vec_cnt, err_cnt and fail_* at edge k+1.
- Last sample accepted at edge k: state is DRAIN after k and DONE after k+1. done and pass are valid from edge k+1 and hold until start or rst.
- Back-to-back vld every cycle is supported, so throughput is 1 sample/cycle.
- busy is 0 in IDLE/DONE and 1 in RUN/DRAIN.
- rst mid-RUN clears everything, including in-flight stage-1 data, and returns to IDLE.

## Configuration
- ADDER_CHK_FIRST_FAIL_EN
  - Defined: first-fail capture registers are built as described above.
  - Undefined: fail_a, fail_b, fail_cin and fail_vld are tied to 0 and the capture registers are not synthesized. Counters and FSM are unchanged.

## Structure
- Package adder_chk_pkg contains:
  - The state enum (IDLE, RUN, DRAIN, DONE).
  - A function that returns TOTAL for a given WIDTH.
- Sub-module adder_chk_cmp implements stage 1, stage 2 and the golden-sum compare. It outputs a registered valid and mismatch.
- The top level holds the FSM, counters and first-fail capture.

## Test plan
- WIDTH=4, correct adder, sweep in order B fastest, then A, then cin (512 vectors) → vec_cnt=512, err_cnt=0, done=1, pass=1, fail_vld=0.
- Same sweep with sum[0] stuck at 0 → err_cnt=255 (saturated; the raw count is 256), pass=0, fail_a=0, fail_b=1, fail_cin=0.
- ERR_CNT_W=4 with cout inverted → err_cnt=15 (saturated), done=1 after 512 samples, fail_a=0, fail_b=0, fail_cin=0.
- start pulse after 100 samples, with vld high the same cycle → next edge gives vec_cnt=0, err_cnt=0, busy=1. A full 512-sample sweep then ends with vec_cnt=512.
- rst asserted mid-sweep, between edges → all outputs 0 immediately and state IDLE. vld afterwards without start leaves vec_cnt=0.
- vld with 3-cycle gaps, plus 5 extra vld pulses after done → vec_cnt stays 512 and done stays 1.
